// File: rtl/mod_arith_pkg.sv
// Shared encodings and sizing helper for the modular add/sub/negate datapath.
package mod_arith_pkg;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_NEG = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_P1   = 2'd1,
        ST_P2   = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // Chunks needed to hold N+1 bits, so the add intermediate a+b never overflows.
    function automatic int nch(input int n, input int chunk);
        return (n + chunk) / chunk;
    endfunction

endpackage

// File: rtl/mod_addsub_pipe_chunk_adder.sv
// One CHUNK-wide slice of the carry chain: a + (inv ? ~b : b) + cin.
module chunk_adder #(
    parameter int CHUNK = 128
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             inv_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o
);

    logic [CHUNK-1:0] b_eff;

    assign b_eff = inv_i ? ~b_i : b_i;
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{CHUNK{1'b0}}, cin_i};

endmodule

// File: rtl/mod_addsub_pipe.sv
// Modular add/sub/negate: raw op pass (P1) then correction-by-m pass (P2),
// each walking the operands LSB-first through a single shared chunk adder.
module mod_addsub_pipe
    import mod_arith_pkg::*;
#(
    parameter int N     = 381,
    parameter int CHUNK = 128
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic [N-1:0] result,
    output logic         done,
    output logic         busy
);

    localparam int NCH = nch(N, CHUNK);
    localparam int W   = NCH * CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic           carry_q;
    logic           c1_q;
    logic [1:0]     mode_q;
    logic [W-1:0]   a_q, b_q, m_q;
    logic [W-1:0]   r1_q, r2_q;
    logic [W-1:0]   r1_d, r2_d;
    logic [N-1:0]   result_q, result_d;
    logic           done_q;
    logic           busy_q;

    logic             sub;
    logic             in_p2;
    int               base;
    logic [CHUNK-1:0] op_a, op_b, sum;
    logic             inv, cin, cout;

    assign sub   = (mode_q == MODE_SUB) || (mode_q == MODE_NEG);
    assign in_p2 = (state_q == ST_P2);

    always_comb begin
        base = int'(cnt_q) * CHUNK;
        op_a = in_p2 ? r1_q[base +: CHUNK] : a_q[base +: CHUNK];
        op_b = in_p2 ? m_q[base +: CHUNK]  : b_q[base +: CHUNK];
        // P1 subtracts b for sub/neg; P2 undoes the opposite way with m.
        inv  = in_p2 ? ~sub : sub;
        cin  = (cnt_q == '0) ? inv : carry_q;
    end

    chunk_adder #(.CHUNK(CHUNK)) u_adder (
        .a_i   (op_a),
        .b_i   (op_b),
        .inv_i (inv),
        .cin_i (cin),
        .sum_o (sum),
        .cout_o(cout)
    );

    always_comb begin
        r1_d = r1_q;
        r2_d = r2_q;
        if (state_q == ST_P1) r1_d[base +: CHUNK] = sum;
        if (state_q == ST_P2) r2_d[base +: CHUNK] = sum;
        // On the last P2 chunk, cout is the final carry c2 (set when r1 >= m for add).
        if (sub) result_d = c1_q ? r1_q[N-1:0] : r2_d[N-1:0];
        else     result_d = cout ? r2_d[N-1:0] : r1_q[N-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            c1_q     <= 1'b0;
            mode_q   <= MODE_ADD;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            r1_q     <= '0;
            r2_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_FIN: begin
                    if (start) begin
                        a_q     <= (mode == MODE_NEG) ? '0 : W'(in_a);
                        b_q     <= W'(in_b);
                        m_q     <= W'(in_m);
                        mode_q  <= mode;
                        cnt_q   <= '0;
                        carry_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_P1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_P1: begin
                    r1_q    <= r1_d;
                    carry_q <= cout;
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        c1_q    <= cout;
                        state_q <= ST_P2;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_P2: begin
                    r2_q    <= r2_d;
                    carry_q <= cout;
                    if (cnt_q == LAST) begin
                        cnt_q    <= '0;
                        result_q <= result_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_FIN;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule
